// File: rtl/fb_pkg.sv
// Shared types and default widths for the framebuffer page arbiter.
package fb_pkg;

  localparam int unsigned FB_ADDR_W     = 10;
  localparam int unsigned FB_DATA_W     = 24;
  localparam int unsigned FB_FIFO_DEPTH = 4;

  typedef logic [FB_DATA_W-1:0] pixel_t;
  typedef logic [FB_ADDR_W-1:0] pix_addr_t;

  typedef struct packed {
    pix_addr_t addr;
    pixel_t    data;
  } wr_req_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO buffering host pixel writes until the RAM is free of scan reads.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = FB_FIFO_DEPTH
) (
  input  logic    clk_in,
  input  logic    rst_n,
  input  logic    push_i,
  input  wr_req_t push_data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output wr_req_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wr_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk_in) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fb_page_arbiter.sv
// Shares a single-port double-buffered pixel RAM between the scan engine (priority reads)
// and a buffered host loader, swapping front/back pages only at scan frame boundaries.
module fb_page_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FB_FIFO_DEPTH
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 host_wr_valid_i,
  output logic                 host_wr_ready_o,
  input  logic [FB_ADDR_W-1:0] host_wr_addr_i,
  input  logic [FB_DATA_W-1:0] host_wr_data_i,
  input  logic                 host_swap_req_i,
  output logic                 host_swap_done_o,
  input  logic                 scan_rd_en_i,
  input  logic [FB_ADDR_W-1:0] scan_rd_addr_i,
  output logic                 scan_rd_valid_o,
  output logic [FB_DATA_W-1:0] scan_rd_data_o,
  input  logic                 scan_frame_end_i,
  output logic                 disp_page_o,
  output logic                 ram_en_o,
  output logic                 ram_we_o,
  output logic [FB_ADDR_W:0]   ram_addr_o,
  output logic [FB_DATA_W-1:0] ram_wdata_o,
  input  logic [FB_DATA_W-1:0] ram_rdata_i
);

  swap_state_e state_q, state_d;
  logic        disp_page_q, disp_page_d;
  logic        rd_valid_q;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  wr_req_t     fifo_in, fifo_head;

  assign host_wr_ready_o = !fifo_full && (state_q != SWAP_PENDING);
  assign fifo_push       = host_wr_valid_i && host_wr_ready_o;
  assign fifo_pop        = !scan_rd_en_i && !fifo_empty;
  assign fifo_in         = '{addr: host_wr_addr_i, data: host_wr_data_i};

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Scan reads always win the port; host writes only ever target the back page.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (scan_rd_en_i) begin
      ram_en_o   = 1'b1;
      ram_addr_o = {disp_page_q, scan_rd_addr_i};
    end else if (!fifo_empty) begin
      ram_en_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_addr_o  = {~disp_page_q, fifo_head.addr};
      ram_wdata_o = fifo_head.data;
    end
  end

  assign scan_rd_valid_o = rd_valid_q;
  assign scan_rd_data_o  = rd_valid_q ? ram_rdata_i : '0;
  assign disp_page_o     = disp_page_q;

  // Swap FSM: frame_end is ignored in IDLE, so a same-cycle request waits a full frame.
  always_comb begin
    state_d          = state_q;
    disp_page_d      = disp_page_q;
    host_swap_done_o = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (host_swap_req_i) state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (scan_frame_end_i && fifo_empty) begin
          disp_page_d      = ~disp_page_q;
          host_swap_done_o = 1'b1;
          state_d          = SWAP_IDLE;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SWAP_IDLE;
      disp_page_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_page_q <= disp_page_d;
      rd_valid_q  <= scan_rd_en_i;
    end
  end

endmodule

// File: tb/tb_fb_page_arbiter.sv
// Directed bench for fb_page_arbiter with a behavioural single-port RAM behind it.
module tb_fb_page_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        host_wr_valid, host_wr_ready;
  logic [9:0]  host_wr_addr;
  logic [23:0] host_wr_data;
  logic        host_swap_req, host_swap_done;
  logic        scan_rd_en;
  logic [9:0]  scan_rd_addr;
  logic        scan_rd_valid;
  logic [23:0] scan_rd_data;
  logic        scan_frame_end;
  logic        disp_page;
  logic        ram_en, ram_we;
  logic [10:0] ram_addr;
  logic [23:0] ram_wdata, ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  fb_page_arbiter dut (
    .clk_in           (clk_in),
    .rst_n            (rst_n),
    .host_wr_valid_i  (host_wr_valid),
    .host_wr_ready_o  (host_wr_ready),
    .host_wr_addr_i   (host_wr_addr),
    .host_wr_data_i   (host_wr_data),
    .host_swap_req_i  (host_swap_req),
    .host_swap_done_o (host_swap_done),
    .scan_rd_en_i     (scan_rd_en),
    .scan_rd_addr_i   (scan_rd_addr),
    .scan_rd_valid_o  (scan_rd_valid),
    .scan_rd_data_o   (scan_rd_data),
    .scan_frame_end_i (scan_frame_end),
    .disp_page_o      (disp_page),
    .ram_en_o         (ram_en),
    .ram_we_o         (ram_we),
    .ram_addr_o       (ram_addr),
    .ram_wdata_o      (ram_wdata),
    .ram_rdata_i      (ram_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Unwritten locations read back as 0x100000 | address.
  logic [23:0] mem [int];
  always @(posedge clk_in) begin
    if (ram_en) begin
      if (ram_we) mem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)]
                                                    : (24'h100000 | 24'(ram_addr));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic half();
    @(negedge clk_in);
  endtask

  task automatic idle_inputs();
    host_wr_valid  = 1'b0;
    host_wr_addr   = '0;
    host_wr_data   = '0;
    host_swap_req  = 1'b0;
    scan_rd_en     = 1'b0;
    scan_rd_addr   = '0;
    scan_frame_end = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    half();
    n_checks++;
    if ({host_wr_ready, disp_page, host_swap_done, scan_rd_valid, ram_en, ram_we} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 100000",
               {host_wr_ready, disp_page, host_swap_done, scan_rd_valid, ram_en, ram_we});
    end
    n_checks++;
    if ({ram_addr, ram_wdata, scan_rd_data} !== 59'h0) begin
      n_fail++;
      $display("FAIL reset_buses: got addr %h wdata %h rdata %h want 0", ram_addr, ram_wdata, scan_rd_data);
    end
    tick();
  endtask

  task automatic test_read();
    scan_rd_en = 1'b1; scan_rd_addr = 10'h005;
    half();
    n_checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 11'h005) begin
      n_fail++;
      $display("FAIL read_issue: got en %b we %b addr %h want 1 0 005", ram_en, ram_we, ram_addr);
    end
    tick();
    scan_rd_en = 1'b0;
    half();
    n_checks++;
    if (scan_rd_valid !== 1'b1 || scan_rd_data !== 24'h100005) begin
      n_fail++;
      $display("FAIL read_data: got valid %b data %h want 1 100005", scan_rd_valid, scan_rd_data);
    end
    tick();
    half();
    n_checks++;
    if (scan_rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_valid_drop: got %b want 0", scan_rd_valid);
    end
    tick();
  endtask

  task automatic test_host_write();
    host_wr_valid = 1'b1; host_wr_addr = 10'h3FF; host_wr_data = 24'hFF0000;
    half();
    n_checks++;
    if (host_wr_ready !== 1'b1 || ram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_accept: got ready %b en %b want 1 0", host_wr_ready, ram_en);
    end
    tick();
    host_wr_valid = 1'b0;
    half();
    n_checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 11'h7FF || ram_wdata !== 24'hFF0000) begin
      n_fail++;
      $display("FAIL wr_commit: got en %b we %b addr %h wdata %h want 1 1 7ff ff0000",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    tick();
    half();
    n_checks++;
    if (ram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_single: got en %b want 0", ram_en);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    scan_rd_en = 1'b1; scan_rd_addr = 10'h000;
    for (int k = 0; k < 4; k++) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = 10'h010 + 10'(k);
      host_wr_data  = 24'h110000 + 24'(k);
      half();
      n_checks++;
      if (host_wr_ready !== 1'b1 || ram_we !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: got ready %b we %b want 1 0", k, host_wr_ready, ram_we);
      end
      tick();
    end
    host_wr_valid = 1'b0;
    half();
    n_checks++;
    if (host_wr_ready !== 1'b0 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL full_starved: got ready %b we %b want 0 0", host_wr_ready, ram_we);
    end
    tick();
    scan_rd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      half();
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== (11'h410 + 11'(k)) || ram_wdata !== (24'h110000 + 24'(k))
          || host_wr_ready !== (k > 0)) begin
        n_fail++;
        $display("FAIL drain_%0d: got we %b addr %h wdata %h ready %b want 1 %h %h %b", k, ram_we,
                 ram_addr, ram_wdata, host_wr_ready, 11'h410 + 11'(k), 24'h110000 + 24'(k), k > 0);
      end
      tick();
    end
    half();
    n_checks++;
    if (ram_en !== 1'b0 || host_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_done: got en %b ready %b want 0 1", ram_en, host_wr_ready);
    end
    tick();
  endtask

  task automatic test_swap_deferred();
    scan_rd_en = 1'b1; scan_rd_addr = 10'h000;
    host_wr_valid = 1'b1; host_wr_addr = 10'h020; host_wr_data = 24'hAAAAAA;
    tick();
    host_wr_addr = 10'h021; host_wr_data = 24'h555555;
    tick();
    host_wr_valid = 1'b0; host_swap_req = 1'b1;
    tick();
    host_swap_req = 1'b0; scan_frame_end = 1'b1;
    half();
    n_checks++;
    if (host_swap_done !== 1'b0 || host_wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_blocked: got done %b ready %b want 0 0", host_swap_done, host_wr_ready);
    end
    tick();
    scan_frame_end = 1'b0; scan_rd_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      half();
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== (11'h420 + 11'(k)) || disp_page !== 1'b0) begin
        n_fail++;
        $display("FAIL swap_drain_%0d: got we %b addr %h page %b want 1 %h 0", k, ram_we, ram_addr,
                 disp_page, 11'h420 + 11'(k));
      end
      tick();
    end
    scan_frame_end = 1'b1;
    half();
    n_checks++;
    if (host_swap_done !== 1'b1 || disp_page !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_fire: got done %b page %b want 1 0", host_swap_done, disp_page);
    end
    tick();
    scan_frame_end = 1'b0;
    scan_rd_en = 1'b1; scan_rd_addr = 10'h3FF;
    half();
    n_checks++;
    if (disp_page !== 1'b1 || host_swap_done !== 1'b0 || host_wr_ready !== 1'b1 || ram_addr !== 11'h7FF) begin
      n_fail++;
      $display("FAIL swap_after: got page %b done %b ready %b addr %h want 1 0 1 7ff",
               disp_page, host_swap_done, host_wr_ready, ram_addr);
    end
    tick();
    scan_rd_addr = 10'h020;
    half();
    n_checks++;
    if (scan_rd_data !== 24'hFF0000 || ram_addr !== 11'h420) begin
      n_fail++;
      $display("FAIL front_read_a: got data %h addr %h want ff0000 420", scan_rd_data, ram_addr);
    end
    tick();
    scan_rd_en = 1'b0;
    half();
    n_checks++;
    if (scan_rd_data !== 24'hAAAAAA) begin
      n_fail++;
      $display("FAIL front_read_b: got %h want aaaaaa", scan_rd_data);
    end
    tick();
  endtask

  task automatic test_swap_same_cycle();
    int dones;
    host_swap_req = 1'b1; scan_frame_end = 1'b1;
    half();
    n_checks++;
    if (host_swap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_done: got %b want 0", host_swap_done);
    end
    tick();
    scan_frame_end = 1'b0;
    half();
    n_checks++;
    if (disp_page !== 1'b1 || host_wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_pending: got page %b ready %b want 1 0", disp_page, host_wr_ready);
    end
    tick();
    host_swap_req = 1'b0;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      scan_frame_end = (c == 1 || c == 4);
      half();
      if (host_swap_done === 1'b1) dones++;
      tick();
    end
    scan_frame_end = 1'b0;
    n_checks++;
    if (dones != 1 || disp_page !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got %0d pulses page %b want 1 0", dones, disp_page);
    end
  endtask

  task automatic test_reset_pending();
    int bad;
    host_swap_req = 1'b1;
    tick();
    host_swap_req = 1'b0; scan_frame_end = 1'b1;
    tick();
    scan_frame_end = 1'b0;
    scan_rd_en = 1'b1; host_wr_valid = 1'b1; host_wr_addr = 10'h030; host_wr_data = 24'h123456;
    tick(); tick();
    host_wr_valid = 1'b0; host_swap_req = 1'b1;
    tick();
    host_swap_req = 1'b0; scan_frame_end = 1'b1;
    tick();
    n_checks++;
    if (disp_page !== 1'b1 || host_wr_ready !== 1'b0 || scan_rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got page %b ready %b valid %b want 1 0 1", disp_page, host_wr_ready, scan_rd_valid);
    end
    scan_frame_end = 1'b0; scan_rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (disp_page !== 1'b0 || host_wr_ready !== 1'b1 || scan_rd_valid !== 1'b0 || host_swap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got page %b ready %b valid %b done %b want 0 1 0 0",
               disp_page, host_wr_ready, scan_rd_valid, host_swap_done);
    end
    tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      scan_frame_end = (c == 2);
      half();
      if (ram_we !== 1'b0 || host_swap_done !== 1'b0 || host_wr_ready !== 1'b1) bad++;
      tick();
    end
    scan_frame_end = 1'b0;
    n_checks++;
    if (bad != 0 || disp_page !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got %0d bad cycles page %b want 0 0", bad, disp_page);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_host_write();
    test_fifo_full();
    test_swap_deferred();
    test_swap_same_cycle();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
